// File: rtl/mkio_bus_controller.sv
`default_nettype none
// ============================================================================
// Module : mkio_bus_controller
// Desc   : MKIO bus-controller sequencer. Sends CW/DWs, collects SW/DWs, 32x16 host buffer.
// Rev    : 1.0  initial release
// ============================================================================
module mkio_bus_controller #(
   parameter int RESP_TIMEOUT = 448,
   parameter int TO_W         = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  rt_addr,
   input  logic        tr,
   input  logic [4:0]  subaddr,
   input  logic [4:0]  word_cnt,
   input  logic        buf_we,
   input  logic [4:0]  buf_addr,
   input  logic [15:0] buf_wdata,
   output logic [15:0] buf_rdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] status,
   output logic        err_timeout,
   output logic        err_parity,
   output logic        err_addr,
   output logic        err_seq,
   output logic        tx_ready,
   output logic        tx_cd,
   output logic [15:0] tx_data,
   input  logic        tx_busy,
   input  logic        rx_done,
   input  logic [15:0] rx_data,
   input  logic        rx_cd,
   input  logic        rx_perr
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_SEND_CW = 3'd1;
   localparam logic [2:0] c_SEND_DW = 3'd2;
   localparam logic [2:0] c_WAIT_TX = 3'd3;
   localparam logic [2:0] c_WAIT_SW = 3'd4;
   localparam logic [2:0] c_RECV_DW = 3'd5;
   localparam logic [2:0] c_FINISH  = 3'd6;

   localparam logic [4:0]      c_BCAST   = 5'd31;
   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(RESP_TIMEOUT - 1);

   logic [2:0]      r_state;
   logic [4:0]      r_rt_addr;
   logic            r_tr;
   logic [4:0]      r_word_cnt;
   logic [5:0]      r_idx;
   logic [TO_W-1:0] r_to;
   logic [15:0]     r_mem [0:31];

   logic       w_bcast;
   logic [5:0] w_nwords;
   logic       w_more_dw;
   logic       w_expired;
   logic       w_sw_match;
   logic       w_mem_we_rx;

   assign w_bcast     = (r_rt_addr == c_BCAST);
   assign w_nwords    = (r_word_cnt == 5'd0) ? 6'd32 : {1'b0, r_word_cnt};
   assign w_more_dw   = !r_tr && (r_idx < w_nwords);
   assign w_expired   = (r_to == c_TO_LAST);
   assign w_sw_match  = (rx_data[15:11] == r_rt_addr);
   assign w_mem_we_rx = (r_state == c_RECV_DW) && rx_done && !rx_cd && !rx_perr;

   // Buffer storage is not reset; the receive path has priority and only runs while busy.
   always_ff @(posedge clk) begin
      if (w_mem_we_rx)
         r_mem[r_idx[4:0]] <= rx_data;
      else if (buf_we && !busy)
         r_mem[buf_addr] <= buf_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_rt_addr   <= '0;
         r_tr        <= 1'b0;
         r_word_cnt  <= '0;
         r_idx       <= '0;
         r_to        <= '0;
         buf_rdata   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         status      <= '0;
         err_timeout <= 1'b0;
         err_parity  <= 1'b0;
         err_addr    <= 1'b0;
         err_seq     <= 1'b0;
         tx_ready    <= 1'b0;
         tx_cd       <= 1'b0;
         tx_data     <= '0;
      end else begin
         done      <= 1'b0;
         buf_rdata <= r_mem[buf_addr];
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_rt_addr   <= rt_addr;
                  r_tr        <= tr;
                  r_word_cnt  <= word_cnt;
                  r_idx       <= '0;
                  r_to        <= '0;
                  status      <= '0;
                  err_timeout <= 1'b0;
                  err_parity  <= 1'b0;
                  err_seq     <= 1'b0;
                  busy        <= 1'b1;
                  tx_cd       <= 1'b1;
                  tx_data     <= {rt_addr, tr, subaddr, word_cnt};
                  if (rt_addr == c_BCAST && tr) begin
                     err_addr <= 1'b1;
                     r_state  <= c_FINISH;
                  end else begin
                     err_addr <= 1'b0;
                     r_state  <= c_SEND_CW;
                  end
               end
            end
            c_SEND_CW, c_SEND_DW: begin
               // Word stays on tx_data/tx_cd until the transmitter acknowledges with tx_busy.
               if (tx_ready && tx_busy) begin
                  tx_ready <= 1'b0;
                  r_state  <= c_WAIT_TX;
               end else if (!tx_ready && !tx_busy) begin
                  tx_ready <= 1'b1;
               end
            end
            c_WAIT_TX: begin
               if (!tx_busy) begin
                  if (w_more_dw) begin
                     tx_data <= r_mem[r_idx[4:0]];
                     tx_cd   <= 1'b0;
                     r_idx   <= r_idx + 6'd1;
                     r_state <= c_SEND_DW;
                  end else if (w_bcast) begin
                     r_state <= c_FINISH;
                  end else begin
                     r_idx   <= '0;
                     r_to    <= '0;
                     r_state <= c_WAIT_SW;
                  end
               end
            end
            c_WAIT_SW: begin
               if (rx_done) begin
                  r_to <= '0;
                  if (rx_perr) begin
                     err_parity <= 1'b1;
                     r_state    <= c_FINISH;
                  end else if (!rx_cd) begin
                     err_seq <= 1'b1;
                     r_state <= c_FINISH;
                  end else if (!w_sw_match) begin
                     err_addr <= 1'b1;
                     r_state  <= c_FINISH;
                  end else begin
                     status  <= rx_data;
                     r_state <= r_tr ? c_RECV_DW : c_FINISH;
                  end
               end else if (w_expired) begin
                  err_timeout <= 1'b1;
                  r_state     <= c_FINISH;
               end else begin
                  r_to <= r_to + 1'b1;
               end
            end
            c_RECV_DW: begin
               if (rx_done) begin
                  r_to <= '0;
                  if (rx_perr) begin
                     err_parity <= 1'b1;
                     r_state    <= c_FINISH;
                  end else if (rx_cd) begin
                     err_seq <= 1'b1;
                     r_state <= c_FINISH;
                  end else begin
                     r_idx <= r_idx + 6'd1;
                     if (r_idx + 6'd1 == w_nwords)
                        r_state <= c_FINISH;
                  end
               end else if (w_expired) begin
                  err_timeout <= 1'b1;
                  r_state     <= c_FINISH;
               end else begin
                  r_to <= r_to + 1'b1;
               end
            end
            c_FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_to    <= '0;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
